// File: rtl/seq_divider.sv
// Sequential signed restoring divider.
// Produces one quotient bit per clock on the magnitudes of the operands, then
// applies the result signs in a final fix-up cycle. Results and flags are
// registered and held until the next division completes.
//
// State table
//   state | meaning
//   IDLE  | waiting for start; operands are latched on the start edge
//   CALC  | one restoring iteration per clock, WIDTH iterations in total
//   FIX   | sign correction, results/flags registered, done pulsed
module seq_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic              load;
    logic              iterate;
    logic              finish;

    logic [CW-1:0]     count;
    logic [WIDTH:0]    p_reg;
    logic [WIDTH-1:0]  q_reg;
    logic [WIDTH-1:0]  dvsr_mag;
    logic              sign_q;
    logic              sign_r;
    logic              zero_q;
    logic              ovf_q;

    // One extra bit above P keeps the trial difference sign visible even when
    // the shifted partial remainder uses all WIDTH+1 bits.
    logic [WIDTH+1:0]  p_shift;
    logic [WIDTH+1:0]  diff;
    logic              step_ok;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and per-state datapath strobes.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        iterate   = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = (divisor == '0) ? FIX : CALC;
                end
            end
            CALC: begin
                iterate = 1'b1;
                if (count == LAST_ITER) begin
                    state_nxt = FIX;
                end
            end
            FIX: begin
                finish    = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);

    // Trial subtraction of the divisor magnitude from the shifted remainder.
    always_comb begin
        p_shift = {p_reg, q_reg[WIDTH-1]};
        diff    = p_shift - {2'b00, dvsr_mag};
        step_ok = ~diff[WIDTH+1];
    end

    // Operand capture and restoring iteration.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count    <= '0;
            p_reg    <= '0;
            q_reg    <= '0;
            dvsr_mag <= '0;
            sign_q   <= 1'b0;
            sign_r   <= 1'b0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else if (load) begin
            // The most-negative value negates to itself, which read unsigned
            // is exactly its magnitude, so no extra bit is needed here.
            q_reg    <= dividend[WIDTH-1] ? -dividend : dividend;
            dvsr_mag <= divisor[WIDTH-1] ? -divisor : divisor;
            sign_q   <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            sign_r   <= dividend[WIDTH-1];
            p_reg    <= '0;
            count    <= '0;
            zero_q   <= (divisor == '0);
            ovf_q    <= (dividend == MOST_NEG) && (divisor == '1);
        end else if (iterate) begin
            p_reg <= step_ok ? diff[WIDTH:0] : p_shift[WIDTH:0];
            q_reg <= {q_reg[WIDTH-2:0], step_ok};
            count <= count + CW'(1);
        end
    end

    // Result registers: loaded only in FIX, held otherwise; done is a pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            done <= finish;
            if (finish) begin
                div_by_zero <= zero_q;
                overflow    <= ovf_q;
                if (zero_q) begin
                    // No iterations ran, so q_reg still holds |dividend|;
                    // re-applying the dividend sign returns the dividend.
                    quotient  <= '1;
                    remainder <= sign_r ? -q_reg : q_reg;
                end else begin
                    // Overflow needs no special case: -(2^(WIDTH-1)) wraps
                    // back to the most-negative value.
                    quotient  <= sign_q ? -q_reg : q_reg;
                    remainder <= sign_r ? -p_reg[WIDTH-1:0] : p_reg[WIDTH-1:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed sign/exception/hazard cases
// followed by randomized divisions compared against an integer-arithmetic model.
module tb_seq_divider;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;
    logic         overflow;

    int n_checks = 0;
    int n_pass   = 0;

    seq_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    endtask

    // Reference: plain signed integer division (truncates toward zero, remainder
    // takes the dividend sign) plus the two exceptional cases.
    function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] q, output logic [W-1:0] r,
                                    output logic z, output logic o);
        int ai;
        int bi;
        ai = $signed(a);
        bi = $signed(b);
        z = 1'b0;
        o = 1'b0;
        if (bi == 0) begin
            q = '1;
            r = a;
            z = 1'b1;
        end else if (ai == -128 && bi == -1) begin
            q = 8'h80;
            r = '0;
            o = 1'b1;
        end else begin
            q = 8'(ai / bi);
            r = 8'(ai % bi);
        end
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Called at #1 after the start edge; counts edges until done.
    task automatic wait_done(input int exp_lat, input string tag);
        int n = 0;
        int busy_bad = 0;
        while (!done && n < 40) begin
            if (!busy) busy_bad++;
            @(posedge clk); #1;
            n++;
        end
        check_eq({tag, "_lat"}, n, exp_lat);
        check_eq({tag, "_busy"}, busy_bad, 0);
        check_eq({tag, "_busy_done"}, int'(busy), 0);
    endtask

    task automatic check_result(input logic [W-1:0] a, input logic [W-1:0] b,
                                input string tag);
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
        logic         o;
        int           qi;
        int           ri;
        ref_div(a, b, q, r, z, o);
        check_eq({tag, "_done"}, int'(done), 1);
        check_eq({tag, "_q"}, int'(quotient), int'(q));
        check_eq({tag, "_r"}, int'(remainder), int'(r));
        check_eq({tag, "_dbz"}, int'(div_by_zero), int'(z));
        check_eq({tag, "_ovf"}, int'(overflow), int'(o));
        if (!z && !o) begin
            qi = $signed(quotient);
            ri = $signed(remainder);
            check_eq({tag, "_inv"}, qi * $signed(b) + ri, $signed(a));
            check_eq({tag, "_rmag"}, int'(iabs(ri) < iabs($signed(b))), 1);
        end
    endtask

    task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b,
                           input string tag);
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
        logic         o;
        @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done((b == '0) ? 1 : W + 1, tag);
        check_result(a, b, tag);
        @(posedge clk); #1;
        ref_div(a, b, q, r, z, o);
        check_eq({tag, "_drop"}, int'(done), 0);
        check_eq({tag, "_hold_q"}, int'(quotient), int'(q));
    endtask

    function automatic logic [W-1:0] pick_operand();
        logic [W-1:0] corners [5] = '{8'h00, 8'h01, 8'hFF, 8'h80, 8'h7F};
        if ($urandom_range(0, 9) < 3) return corners[$urandom_range(0, 4)];
        return W'($urandom_range(0, 255));
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int done_seen;
        logic [W-1:0] a;
        logic [W-1:0] b;

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_done", int'(done), 0);
        check_eq("rst_q", int'(quotient), 0);
        check_eq("rst_r", int'(remainder), 0);
        check_eq("rst_flags", int'({div_by_zero, overflow}), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic and sign cases
        run_div(8'd20, 8'd5, "t20_5");
        run_div(8'hCE, 8'd5, "tm50_5");
        run_div(8'd7, 8'hFE, "t7_m2");
        run_div(8'hF9, 8'd2, "tm7_2");
        run_div(8'hF9, 8'hFE, "tm7_m2");

        // Exceptions and flag clearing
        run_div(8'd5, 8'd0, "t5_0");
        run_div(8'd100, 8'd7, "t100_7");
        run_div(8'h80, 8'hFF, "tovf");
        run_div(8'h80, 8'h01, "tm128_1");

        // start held high, operands change mid-run, back-to-back acceptance
        @(negedge clk);
        start    = 1'b1;
        dividend = 8'd100;
        divisor  = 8'd7;
        @(posedge clk); #1;
        dividend = 8'hCE;
        divisor  = 8'd5;
        wait_done(W + 1, "hold1");
        check_result(8'd100, 8'd7, "hold1");
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(W + 1, "hold2");
        check_result(8'hCE, 8'd5, "hold2");

        // Reset at iteration 4 aborts, after a result with nonzero flags
        run_div(8'h80, 8'hFF, "pre_rst");
        @(negedge clk);
        start    = 1'b1;
        dividend = 8'd100;
        divisor  = 8'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_eq("abort_busy", int'(busy), 0);
        check_eq("abort_done", int'(done), 0);
        check_eq("abort_q", int'(quotient), 0);
        check_eq("abort_r", int'(remainder), 0);
        check_eq("abort_flags", int'({div_by_zero, overflow}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (done) done_seen++;
        end
        check_eq("abort_no_done", done_seen, 0);
        run_div(8'h9C, 8'd7, "recover");

        // Randomized operands with corner values mixed in
        for (int i = 0; i < 2500; i++) begin
            a = pick_operand();
            b = pick_operand();
            run_div(a, b, "rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
